// File: rtl/vx_tex_sat_pipe.sv
// Multi-lane pipelined fixed-point saturator for the texture unit.
// S1 rounds half-up and drops the fraction bits. S2 clamps each lane to an unsigned or signed
// OUT_W range and flags any lane that was clamped. The block has an elastic valid/ready
// handshake and a sticky saturation event counter.
module vx_tex_sat_pipe #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned IN_W      = 16,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned FRAC_W    = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic                       signed_in,
    input  logic [NUM_LANES*IN_W-1:0]  data_in,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [NUM_LANES*OUT_W-1:0] data_out,
    output logic [NUM_LANES-1:0]       sat_out,
    output logic [CNT_W-1:0]           sat_count,
    input  logic                       clear_cnt
);

    // One guard bit above IN_W so that adding the rounding constant can never wrap.
    localparam int unsigned RW = IN_W + 1;

    localparam logic signed [RW-1:0] UMAX = RW'((1 << OUT_W) - 1);
    localparam logic signed [RW-1:0] SMAX = RW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] SMIN = ~SMAX;

    localparam logic [OUT_W-1:0] CODE_UMAX = {OUT_W{1'b1}};
    localparam logic [OUT_W-1:0] CODE_SMAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] CODE_SMIN = {1'b1, {(OUT_W - 1){1'b0}}};

    if ((FRAC_W + OUT_W) >= IN_W || OUT_W < 2) begin : g_param_check
        $error("vx_tex_sat_pipe: need FRAC_W + OUT_W < IN_W and OUT_W >= 2");
    end

    logic                       s1_valid_q, s2_valid_q;
    logic                       s1_signed_q;
    logic [NUM_LANES*RW-1:0]    s1_data_q;
    logic [NUM_LANES*RW-1:0]    round_d;
    logic [NUM_LANES*OUT_W-1:0] s2_data_q, clamp_data_d;
    logic [NUM_LANES-1:0]       s2_sat_q, clamp_sat_d;
    logic [CNT_W-1:0]           sat_count_q;
    logic signed [RW-1:0]       lane_r;
    logic                       stage1_en, stage2_en, out_xfer;

    // A stage may load when it is empty or when the stage after it frees up this cycle.
    assign stage2_en = ~s2_valid_q | ready_out;
    assign stage1_en = ~s1_valid_q | stage2_en;
    assign ready_in  = stage1_en;
    assign out_xfer  = s2_valid_q & ready_out;

    assign valid_out = s2_valid_q;
    assign data_out  = s2_data_q;
    assign sat_out   = s2_sat_q;
    assign sat_count = sat_count_q;

    // Per-lane round-half-up and arithmetic shift on the sign-extended input.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_round
        logic signed [RW-1:0] x_ext;
        assign x_ext = {data_in[i*IN_W+IN_W-1], data_in[i*IN_W +: IN_W]};
        if (FRAC_W > 0) begin : g_rnd
            localparam logic signed [RW-1:0] HALF = RW'(1 << (FRAC_W - 1));
            assign round_d[i*RW +: RW] = (x_ext + HALF) >>> FRAC_W;
        end else begin : g_pass
            assign round_d[i*RW +: RW] = x_ext;
        end
    end

    // Clamp each S1 lane into the selected range and flag out-of-range lanes.
    always_comb begin
        clamp_data_d = '0;
        clamp_sat_d  = '0;
        lane_r       = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_r = s1_data_q[i*RW +: RW];
            clamp_data_d[i*OUT_W +: OUT_W] = lane_r[OUT_W-1:0];
            if (s1_signed_q) begin
                if (lane_r < SMIN) begin
                    clamp_data_d[i*OUT_W +: OUT_W] = CODE_SMIN;
                    clamp_sat_d[i] = 1'b1;
                end else if (lane_r > SMAX) begin
                    clamp_data_d[i*OUT_W +: OUT_W] = CODE_SMAX;
                    clamp_sat_d[i] = 1'b1;
                end
            end else begin
                if (lane_r[RW-1]) begin
                    clamp_data_d[i*OUT_W +: OUT_W] = '0;
                    clamp_sat_d[i] = 1'b1;
                end else if (lane_r > UMAX) begin
                    clamp_data_d[i*OUT_W +: OUT_W] = CODE_UMAX;
                    clamp_sat_d[i] = 1'b1;
                end
            end
        end
    end

    // S1 register: rounded lanes plus the clamp mode travelling with them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_data_q   <= '0;
        end else if (stage1_en) begin
            s1_valid_q <= valid_in;
            if (valid_in) begin
                s1_signed_q <= signed_in;
                s1_data_q   <= round_d;
            end
        end
    end

    // S2 register: clamped result; holds steady while downstream stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= '0;
        end else if (stage2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= clamp_data_d;
                s2_sat_q  <= clamp_sat_d;
            end
        end
    end

    // Sticky count of saturating output transfers; clear has priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_count_q <= '0;
        end else if (clear_cnt) begin
            sat_count_q <= '0;
        end else if (out_xfer && (|s2_sat_q) && (sat_count_q != '1)) begin
            sat_count_q <= sat_count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vx_tex_sat_pipe.sv
// Self-checking bench for vx_tex_sat_pipe: directed vectors with literal expectations plus a
// transaction-level reference model checked on every cycle at the falling clock edge.
module tb_vx_tex_sat_pipe;

    localparam int NL = 2;
    localparam int IW = 16;
    localparam int OW = 8;
    localparam int FW = 4;
    // Narrow counter so the sticky limit is reachable in a few hundred transfers.
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             valid_in = 1'b0;
    logic             signed_in = 1'b0;
    logic [NL*IW-1:0] data_in = '0;
    logic             ready_out = 1'b1;
    logic             clear_cnt = 1'b0;
    logic             ready_in;
    logic             valid_out;
    logic [NL*OW-1:0] data_out;
    logic [NL-1:0]    sat_out;
    logic [CW-1:0]    sat_count;

    vx_tex_sat_pipe #(
        .NUM_LANES (NL),
        .IN_W      (IW),
        .OUT_W     (OW),
        .FRAC_W    (FW),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .signed_in (signed_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .sat_out   (sat_out),
        .sat_count (sat_count),
        .clear_cnt (clear_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int floor_div(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic void lane_ref(input logic [IW-1:0] x, input logic sgn,
                                     output logic [OW-1:0] y, output logic f);
        int v, r, lo, hi;
        v  = int'($signed(x));
        r  = (FW > 0) ? floor_div(v + (1 << (FW - 1)), 1 << FW) : v;
        lo = sgn ? -(1 << (OW - 1)) : 0;
        hi = sgn ? (1 << (OW - 1)) - 1 : (1 << OW) - 1;
        f  = 1'b0;
        if (r < lo) begin
            r = lo;
            f = 1'b1;
        end else if (r > hi) begin
            r = hi;
            f = 1'b1;
        end
        y = OW'(r);
    endfunction

    typedef struct packed {
        logic [NL*OW-1:0] d;
        logic [NL-1:0]    s;
    } exp_t;

    function automatic exp_t txn_ref(input logic [NL*IW-1:0] din, input logic sgn);
        exp_t         e;
        logic [OW-1:0] y;
        logic          f;
        e = '0;
        for (int i = 0; i < NL; i++) begin
            lane_ref(din[i*IW +: IW], sgn, y, f);
            e.d[i*OW +: OW] = y;
            e.s[i] = f;
        end
        return e;
    endfunction

    exp_t          q[$];
    int            exp_cnt = 0;
    int            n_out = 0;
    logic          held = 1'b0;
    logic [NL*OW-1:0] held_d;
    logic [NL-1:0]    held_s;

    // Compare DUT against the model every cycle, then advance the model by one clock edge.
    always @(negedge clk) begin : mon
        exp_t e;
        logic any;
        if (!reset_n) begin
            q.delete();
            exp_cnt = 0;
            held = 1'b0;
            chk("rst valid_out", valid_out, 0);
            chk("rst data_out", data_out, 0);
            chk("rst sat_out", sat_out, 0);
            chk("rst sat_count", sat_count, 0);
        end else begin
            any = 1'b0;
            if (held) begin
                chk("stall valid_out", valid_out, 1);
                chk("stall data_out", data_out, held_d);
                chk("stall sat_out", sat_out, held_s);
            end
            chk("sat_count", sat_count, exp_cnt);
            if (valid_out) begin
                if (q.size() == 0) begin
                    chk("spurious valid_out", valid_out, 0);
                end else begin
                    e = q[0];
                    chk("data_out", data_out, e.d);
                    chk("sat_out", sat_out, e.s);
                    if (ready_out) begin
                        void'(q.pop_front());
                        n_out++;
                        any = |e.s;
                    end
                end
            end
            held   = valid_out && !ready_out;
            held_d = data_out;
            held_s = sat_out;
            if (clear_cnt) exp_cnt = 0;
            else if (any && exp_cnt < CNT_MAX) exp_cnt++;
            if (valid_in && ready_in) q.push_back(txn_ref(data_in, signed_in));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single transaction into an empty pipe: checks exact 2-cycle latency and literal result.
    task automatic xfer1(input string nm, input logic sgn, input logic [IW-1:0] l0,
                         input logic [IW-1:0] l1, input logic [NL*OW-1:0] ed,
                         input logic [NL-1:0] es);
        ready_out = 1'b1;
        chk({nm, " ready_in"}, ready_in, 1);
        valid_in  = 1'b1;
        signed_in = sgn;
        data_in   = {l1, l0};
        step();
        valid_in = 1'b0;
        chk({nm, " early valid"}, valid_out, 0);
        step();
        chk({nm, " valid"}, valid_out, 1);
        chk({nm, " data"}, data_out, ed);
        chk({nm, " sat"}, sat_out, es);
        step();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int sent, base_out;
        logic saw_drop;

        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("reset valid_out", valid_out, 0);
        chk("reset sat_count", sat_count, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        chk("ready_in after reset", ready_in, 1);
        step();

        // Basic unsigned / signed clamping with literal results.
        xfer1("t1", 1'b0, 16'h0FF8, 16'h00F7, 16'h0FFF, 2'b01);
        chk("t1 count", sat_count, 1);
        xfer1("t2", 1'b0, 16'hFFF0, 16'hFFF8, 16'h0000, 2'b01);
        chk("t2 count", sat_count, 2);
        xfer1("t3a", 1'b1, 16'h0800, 16'hF7F0, 16'h807F, 2'b11);
        xfer1("t3b", 1'b1, 16'h07F0, 16'hF800, 16'h807F, 2'b00);
        chk("t3 count", sat_count, 3);
        xfer1("tovf", 1'b0, 16'h7FFF, 16'h8000, 16'h00FF, 2'b11);
        xfer1("tbnd", 1'b0, 16'h0FF0, 16'h0000, 16'h00FF, 2'b00);
        chk("tbnd count", sat_count, 4);

        // Back-to-back stream with a downstream stall.
        sent = 0;
        saw_drop = 1'b0;
        base_out = n_out;
        for (int c = 0; c < 24; c++) begin
            ready_out = !(c >= 3 && c <= 5);
            if (sent < 8) begin
                valid_in  = 1'b1;
                signed_in = sent[0];
                data_in   = {16'hFF00 + 16'(sent * 16'h0050), 16'(sent * 16'h0230)};
            end else begin
                valid_in = 1'b0;
            end
            #1;
            if (!ready_in) saw_drop = 1'b1;
            if (valid_in && ready_in) sent++;
            step();
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        chk("t4 sent", sent, 8);
        chk("t4 ready_in dropped", saw_drop, 1);
        chk("t4 outputs", n_out - base_out, 8);
        chk("t4 drained", q.size(), 0);

        // Sticky counter and clear priority.
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        chk("t5 cleared", sat_count, 0);
        for (int i = 0; i < CNT_MAX - 1; i++) begin
            valid_in  = 1'b1;
            signed_in = 1'b0;
            data_in   = {16'h0000, 16'h7FFF};
            step();
        end
        valid_in = 1'b0;
        repeat (3) step();
        chk("t5 count max-1", sat_count, CNT_MAX - 1);
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        repeat (3) step();
        chk("t5 count sticks", sat_count, CNT_MAX);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        chk("t5 valid before clear", valid_out, 1);
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        chk("t5 clear beats incr", sat_count, 0);

        // Reset with both stages full.
        xfer1("t6pre", 1'b0, 16'h7FFF, 16'h0000, 16'h00FF, 2'b01);
        chk("t6pre count", sat_count, 1);
        ready_out = 1'b0;
        valid_in  = 1'b1;
        signed_in = 1'b0;
        data_in   = {16'h1234, 16'h7FFF};
        step();
        data_in = {16'h8000, 16'h0550};
        step();
        valid_in = 1'b0;
        chk("t6 full valid_out", valid_out, 1);
        chk("t6 full ready_in", ready_in, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6 async valid_out", valid_out, 0);
        chk("t6 async sat_out", sat_out, 0);
        chk("t6 async data_out", data_out, 0);
        chk("t6 async sat_count", sat_count, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        ready_out = 1'b1;
        chk("t6 ready_in after release", ready_in, 1);
        step();
        xfer1("t6post", 1'b1, 16'h0100, 16'hFF00, 16'hF010, 2'b00);

        repeat (3) step();
        chk("final drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
